// File: rtl/chicken_pkg.sv
// chicken_pkg: shared types and constants for the chicken board game turn logic.
// Holds the turn FSM encoding, the player (T) codes, the picture width and the
// face-down card picture ROM.
package chicken_pkg;

    // Picture code width shared by cards and board tiles.
    localparam int PIC_W = 4;

    // Number of face-down picture cards on the table.
    localparam int CARD_COUNT = 12;

    // Turn sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PICK,
        ST_REVEAL,
        ST_JUDGE,
        ST_CHECK,
        ST_PASS,
        ST_OVER
    } state_t;

    // Player codes driven on T. T_NONE only appears out of reset.
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_P1   = 2'b01;
    localparam logic [1:0] T_P2   = 2'b10;
    localparam logic [1:0] T_P3   = 2'b11;

    // Card picture ROM: pictures 0..5, each printed on two cards (idx i -> i mod 6).
    // Entry 0 is the least significant nibble.
    localparam logic [CARD_COUNT-1:0][PIC_W-1:0] CARD_ROM = 48'h5432_1054_3210;

    // Picture printed on card idx; indices past the deck read as 0.
    function automatic logic [PIC_W-1:0] card_pic(input logic [3:0] idx);
        logic [PIC_W-1:0] pic;
        pic = '0;
        for (int i = 0; i < CARD_COUNT; i++) begin
            if (idx == 4'(i)) begin
                pic = CARD_ROM[i];
            end
        end
        return pic;
    endfunction

    // Turn order P1 -> P2 -> P3 -> P1; never yields T_NONE.
    function automatic logic [1:0] next_player(input logic [1:0] t);
        logic [1:0] nxt;
        case (t)
            T_P1:    nxt = T_P2;
            T_P2:    nxt = T_P3;
            default: nxt = T_P1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/reveal_timer.sv
// reveal_timer: one-shot down-counter that times how long a picked card stays
// face up. A load pulse arms it; done pulses for exactly one cycle on the
// CYCLES-th cycle after the load, then the timer goes idle until reloaded.
module reveal_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // Next-state: reload on load, otherwise count down while running and stop at zero.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves
        // it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = CNT_LAST;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Terminal count of an armed timer.
    assign done = run_q && (cnt_q == '0);

    // Counter state registers; reset aborts any reveal in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/turn_ctrl.sv
// turn_ctrl: runs player turns for the 3-player chicken game. Accepts card picks,
// reveals the card picture for REVEAL_CYCLES, judges it against the tile ahead
// (T and B go to the win checker), then reads back W to end the game.
// Build option: define TURN_TIMEOUT_EN to force a pass after TURN_TIMEOUT idle
// cycles in WAIT_PICK; without it a player may think indefinitely.
module turn_ctrl
    import chicken_pkg::*;
#(
    parameter int NUM_CARDS     = CARD_COUNT,
    parameter int REVEAL_CYCLES = 25000000,
    parameter int TURN_TIMEOUT  = 250000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pick_valid,
    input  logic [3:0]           pick_idx,
    input  logic [PIC_W-1:0]     target_pic,
    input  logic                 W,
    output logic [1:0]           T,
    output logic                 B,
    output logic                 judge_valid,
    output logic [NUM_CARDS-1:0] open_mask,
    output logic [PIC_W-1:0]     revealed_pic,
    output logic                 game_over,
    output logic [1:0]           winner
);

    state_t               state_q;
    logic [1:0]           t_q;
    logic                 b_q;
    logic                 judge_valid_q;
    logic [NUM_CARDS-1:0] open_mask_q;
    logic [PIC_W-1:0]     pic_q;
    logic [PIC_W-1:0]     revealed_pic_q;
    logic                 game_over_q;
    logic [1:0]           winner_q;

    logic [NUM_CARDS-1:0] pick_sel;
    logic                 pick_in_range;
    logic                 pick_accept;
    logic [PIC_W-1:0]     pick_pic;
    logic                 pic_match;
    logic                 timer_done;
    logic                 timeout_hit;

    // A pick counts only while already waiting, in range, and on a still-hidden card.
    assign pick_in_range = (32'(pick_idx) < NUM_CARDS);
    assign pick_sel      = NUM_CARDS'(1) << pick_idx;
    assign pick_accept   = (state_q == ST_WAIT_PICK) && pick_valid && pick_in_range
                           && ((open_mask_q & pick_sel) == '0);
    assign pick_pic      = card_pic(pick_idx);
    assign pic_match     = (pic_q == target_pic);

    reveal_timer #(
        .CYCLES (REVEAL_CYCLES)
    ) u_reveal_timer (
        .clk  (clk),
        .rst  (rst),
        .load (pick_accept),
        .done (timer_done)
    );

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT - 1);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

    // Idle counter: runs only while waiting for a pick; any other state, an
    // accepted pick or the timeout itself returns it to zero.
    always_comb begin
        idle_cnt_d = '0;
        if ((state_q == ST_WAIT_PICK) && !pick_accept && (idle_cnt_q != TO_LAST)) begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
    end

    assign timeout_hit = (state_q == ST_WAIT_PICK) && !pick_accept && (idle_cnt_q == TO_LAST);

    // Idle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TURN_TIMEOUT;
`endif

    // Turn FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q        <= ST_IDLE;
            t_q            <= T_NONE;
            b_q            <= 1'b0;
            judge_valid_q  <= 1'b0;
            open_mask_q    <= '0;
            pic_q          <= '0;
            revealed_pic_q <= '0;
            game_over_q    <= 1'b0;
            winner_q       <= T_NONE;
        end else begin
            // judge_valid is a one-cycle pulse; only the REVEAL exit raises it.
            judge_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // start wins over any pick presented in the same cycle.
                    if (start) begin
                        state_q        <= ST_WAIT_PICK;
                        t_q            <= T_P1;
                        b_q            <= 1'b0;
                        open_mask_q    <= '0;
                        revealed_pic_q <= '0;
                        game_over_q    <= 1'b0;
                        winner_q       <= T_NONE;
                    end
                end

                ST_WAIT_PICK: begin
                    if (pick_accept) begin
                        pic_q          <= pick_pic;
                        revealed_pic_q <= pick_pic;
                        open_mask_q    <= open_mask_q | pick_sel;
                        state_q        <= ST_REVEAL;
                    end else if (timeout_hit) begin
                        state_q <= ST_PASS;
                    end
                end

                ST_REVEAL: begin
                    if (timer_done) begin
                        state_q        <= ST_JUDGE;
                        judge_valid_q  <= 1'b1;
                        revealed_pic_q <= '0;
                    end
                end

                ST_JUDGE: begin
                    // Keep this cycle's comparison so B holds until the next judgement.
                    b_q     <= pic_match;
                    state_q <= ST_CHECK;
                end

                ST_CHECK: begin
                    // W reflects the win checker's update made during JUDGE.
                    if (W) begin
                        state_q     <= ST_OVER;
                        winner_q    <= t_q;
                        game_over_q <= 1'b1;
                    end else if (b_q && !(&open_mask_q)) begin
                        state_q <= ST_WAIT_PICK;
                    end else begin
                        // A miss, or a full board of matches, hands the turn on.
                        state_q <= ST_PASS;
                    end
                end

                ST_PASS: begin
                    open_mask_q    <= '0;
                    revealed_pic_q <= '0;
                    t_q            <= next_player(t_q);
                    state_q        <= ST_WAIT_PICK;
                end

                ST_OVER: begin
                    // T keeps showing the winner; picks are ignored until restart.
                    if (start) begin
                        state_q        <= ST_IDLE;
                        t_q            <= T_P1;
                        b_q            <= 1'b0;
                        open_mask_q    <= '0;
                        revealed_pic_q <= '0;
                        game_over_q    <= 1'b0;
                        winner_q       <= T_NONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // B is live during JUDGE so it lines up with judge_valid for the win
    // checker; outside JUDGE it shows the last judgement.
    assign B            = (state_q == ST_JUDGE) ? pic_match : b_q;
    assign T            = t_q;
    assign judge_valid  = judge_valid_q;
    assign open_mask    = open_mask_q;
    assign revealed_pic = revealed_pic_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: doc/turn_ctrl.md
Name: turn_ctrl

Overview:
- Upstream stage of the win checker: runs player turns for the 3-player chicken board game.
- Accepts card picks, reveals each card's picture for a hold time, and compares it against the picture of the tile the current chicken must step onto.
- Drives turn index T and match flag B into the win checker, then reads back W to end the game.

Parameters:
- NUM_CARDS, 12, number of face-down picture cards (pick index range 0..NUM_CARDS-1).
- PIC_W, 4, picture code width.
- REVEAL_CYCLES, 25000000, clk cycles a picked card stays revealed before judging (>=1).
- TURN_TIMEOUT, 250000000, idle cycles in WAIT_PICK before a forced pass (TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse, begins a game
- pick_valid  in  1  single-cycle pulse, pick_idx is valid
- pick_idx  in  4  chosen card index
- target_pic  in  PIC_W  picture of the tile ahead of the current player
- W  in  1  win flag from the win checker
- T  out  2  current player: 2'b01 P1, 2'b10 P2, 2'b11 P3, 2'b00 none
- B  out  1  match result, meaningful when judge_valid=1
- judge_valid  out  1  single-cycle pulse, one judgement issued
- open_mask  out  NUM_CARDS  cards revealed during the current turn
- revealed_pic  out  PIC_W  picture of the card being revealed, 0 otherwise
- game_over  out  1  sticky until rst or next start
- winner  out  2  T value of the winning player, 0 before a win

Behaviour:
- Reset (async) puts all outputs at 0 and the state at IDLE.
- States: IDLE, WAIT_PICK, REVEAL, JUDGE, CHECK, PASS, OVER.
- IDLE:
  - start -> WAIT_PICK next cycle.
  - T=01, open_mask cleared, winner=0, game_over=0.
- WAIT_PICK: a pick is ignored (no state change) if pick_idx>=NUM_CARDS or open_mask[pick_idx]=1. Otherwise:
  - latch the card picture from the package ROM;
  - set open_mask[pick_idx];
  - load the reveal timer;
  - -> REVEAL.
- REVEAL:
  - revealed_pic = latched picture.
  - Timer counts REVEAL_CYCLES; at terminal count -> JUDGE.
  - pick_valid is ignored here.
- JUDGE:
  - judge_valid=1 for exactly one cycle.
  - B = (latched pic == target_pic), sampled this cycle.
  - -> CHECK.
- CHECK (one cycle after JUDGE; the win checker updates during JUDGE):
  - W=1 -> OVER, with winner=T.
  - else if B was 1 and open_mask is not all ones -> WAIT_PICK; the same player continues.
  - else -> PASS.
- PASS:
  - open_mask cleared, revealed_pic=0.
  - T advances 01->10->11->01 (wrap from 11 to 01, never 00).
  - -> WAIT_PICK.
- OVER:
  - game_over=1, T holds the winner, further picks are ignored.
  - start -> IDLE and then a new game.
- Every state except OVER ignores start.
- B holds its last value between judgements; it is cleared in IDLE.
- A start and a pick in the same cycle in IDLE: start wins and the pick is dropped.
- A pick in the same cycle as entering WAIT_PICK (from CHECK/PASS) is not accepted; only picks sampled while already in WAIT_PICK count.
- rst mid-REVEAL aborts immediately: timer cleared, outputs back to reset values.
- Revealing all NUM_CARDS with matches forces PASS, so a turn never stalls.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- With it defined:
  - a counter runs in WAIT_PICK and resets on every accepted pick and on state entry;
  - reaching TURN_TIMEOUT -> PASS, with no judge_valid issued.
- Without it: WAIT_PICK waits indefinitely; no counter logic is present.

Decomposition:
- Package chicken_pkg holds:
  - state encoding;
  - T encodings P1/P2/P3/NONE;
  - PIC_W;
  - card picture ROM constant of NUM_CARDS entries (default pictures 0..5, each twice: idx i -> i mod 6).
- Sub-module reveal_timer:
  - ports clk, rst, load, done;
  - parameter CYCLES;
  - down-counter, done asserted for one cycle at terminal count.

Test Plan (REVEAL_CYCLES=4, TURN_TIMEOUT=20 in the bench):
- Reset/start: rst, then start -> T=01, open_mask=0, game_over=0 the next cycle; all outputs 0 during rst.
- Match continues:
  - target_pic=3, pick_idx=3 -> revealed_pic=3 for 4 cycles;
  - judge_valid pulse with B=1;
  - T stays 01, open_mask=12'h008.
- Mismatch passes:
  - target_pic=2, pick_idx=5 -> B=0;
  - PASS gives T=10, open_mask=0;
  - repeat from P3 -> T wraps 11->01.
- Illegal picks: pick_idx=12, or a repeat of an open card -> no state change, no judge_valid.
- Win:
  - W=1 held during the judgement for P2 -> game_over=1, winner=10;
  - a following pick is ignored; start -> IDLE.
- Async reset mid-REVEAL: assert rst for 1 cycle at timer=2 -> state IDLE and revealed_pic=0 immediately; no judge_valid.
- TURN_TIMEOUT_EN: no pick for 20 cycles -> T advances with no judge_valid pulse.
